// File: rtl/sym_err_cnt.sv
// sym_err_cnt: windowed symbol/bit error counter for a 4-ASK link with lock detection.
// Windows are delimited by clk_en-qualified hold pulses; counts latch and reload at each boundary.
module sym_err_cnt #(
    parameter int CNT_W    = 22,
    parameter int SKIP_WIN = 1,
    parameter int LOCK_THR = 0,
    parameter int LOCK_WIN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             hold,
    input  logic [1:0]       rx_data,
    input  logic [1:0]       ref_data,
    output logic [CNT_W-1:0] sym_err,
    output logic [CNT_W:0]   bit_err,
    output logic [CNT_W-1:0] sym_total,
    output logic             err_valid,
    output logic             sat,
    output logic             lock,
    output logic [1:0]       state
);
    localparam int SK_W = SKIP_WIN > 0 ? $clog2(SKIP_WIN + 1) : 1;
    localparam int LC_W = LOCK_WIN > 0 ? $clog2(LOCK_WIN + 1) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, COUNT = 2'd2, ILLEGAL = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [SK_W-1:0]  skip_q, skip_d;
    logic [CNT_W-1:0] tot_acc_q, tot_acc_d, err_acc_q, err_acc_d;
    logic [CNT_W:0]   bit_acc_q, bit_acc_d;
    logic             sat_acc_q, sat_acc_d;
    logic [CNT_W-1:0] sym_err_q, sym_err_d, sym_total_q, sym_total_d;
    logic [CNT_W:0]   bit_err_q, bit_err_d;
    logic             sat_q, sat_d, err_valid_q, err_valid_d, lock_q, lock_d;
    logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;

    logic [1:0]       diff;
    logic [CNT_W:0]   tot_sum, err_sum;
    logic [CNT_W+1:0] bit_sum;
    logic [CNT_W-1:0] tot_new, err_new;
    logic [CNT_W:0]   bit_new;
    logic             ovf, good;

    // Accumulator values including the current symbol, clipped at all-ones.
    always_comb begin
        diff    = rx_data ^ ref_data;
        tot_sum = {1'b0, tot_acc_q} + (CNT_W+1)'(1);
        err_sum = {1'b0, err_acc_q} + (CNT_W+1)'(|diff);
        bit_sum = {1'b0, bit_acc_q} + (CNT_W+2)'(diff[0]) + (CNT_W+2)'(diff[1]);
        tot_new = tot_sum[CNT_W] ? '1 : tot_sum[CNT_W-1:0];
        err_new = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        bit_new = bit_sum[CNT_W+1] ? '1 : bit_sum[CNT_W:0];
        ovf     = sat_acc_q | tot_sum[CNT_W] | err_sum[CNT_W] | bit_sum[CNT_W+1];
        good    = (err_new <= CNT_W'(LOCK_THR)) && !ovf;
    end

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        tot_acc_d   = tot_acc_q;
        err_acc_d   = err_acc_q;
        bit_acc_d   = bit_acc_q;
        sat_acc_d   = sat_acc_q;
        sym_err_d   = sym_err_q;
        bit_err_d   = bit_err_q;
        sym_total_d = sym_total_q;
        sat_d       = sat_q;
        lock_cnt_d  = lock_cnt_q;
        lock_d      = lock_q;
        err_valid_d = 1'b0;
        if (state_q == ILLEGAL) begin
            state_d = IDLE;
        end else if (clk_en) begin
            if (state_q == IDLE && hold) begin
                skip_d = '0;
                if (SKIP_WIN == 0) state_d = COUNT;
                else state_d = SKIP;
            end
            if (state_q == SKIP && hold) begin
                skip_d = skip_q + SK_W'(1);
                if (skip_q == SK_W'(SKIP_WIN - 1)) state_d = COUNT;
            end
            if (state_q == COUNT) begin
                tot_acc_d = hold ? '0 : tot_new;
                err_acc_d = hold ? '0 : err_new;
                bit_acc_d = hold ? '0 : bit_new;
                sat_acc_d = hold ? 1'b0 : ovf;
                if (hold) begin
                    sym_err_d   = err_new;
                    bit_err_d   = bit_new;
                    sym_total_d = tot_new;
                    sat_d       = ovf;
                    err_valid_d = 1'b1;
                    lock_cnt_d  = !good ? '0 :
                                  (lock_cnt_q == LC_W'(LOCK_WIN)) ? lock_cnt_q : lock_cnt_q + LC_W'(1);
                    lock_d      = lock_cnt_d == LC_W'(LOCK_WIN);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            skip_q      <= '0;
            tot_acc_q   <= '0;
            err_acc_q   <= '0;
            bit_acc_q   <= '0;
            sat_acc_q   <= 1'b0;
            sym_err_q   <= '0;
            bit_err_q   <= '0;
            sym_total_q <= '0;
            sat_q       <= 1'b0;
            lock_cnt_q  <= '0;
            lock_q      <= 1'b0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            tot_acc_q   <= tot_acc_d;
            err_acc_q   <= err_acc_d;
            bit_acc_q   <= bit_acc_d;
            sat_acc_q   <= sat_acc_d;
            sym_err_q   <= sym_err_d;
            bit_err_q   <= bit_err_d;
            sym_total_q <= sym_total_d;
            sat_q       <= sat_d;
            lock_cnt_q  <= lock_cnt_d;
            lock_q      <= lock_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign sym_err   = sym_err_q;
    assign bit_err   = bit_err_q;
    assign sym_total = sym_total_q;
    assign err_valid = err_valid_q;
    assign sat       = sat_q;
    assign lock      = lock_q;
    assign state     = state_q;
endmodule

// File: tb/tb_sym_err_cnt.sv
// tb_sym_err_cnt: checks a default instance and a CNT_W=4 instance against a window-level model.
// The model keeps each window's per-symbol bit errors in a queue and sums them at the boundary.
module tb_sym_err_cnt;
    localparam int SKIP_WIN = 1;
    localparam int LOCK_THR = 0;
    localparam int LOCK_WIN = 2;

    logic        clk, reset, clk_en, hold;
    logic [1:0]  rx_data, ref_data;
    logic [21:0] m_sym_err, m_sym_total;
    logic [22:0] m_bit_err;
    logic        m_err_valid, m_sat, m_lock;
    logic [1:0]  m_state;
    logic [3:0]  s_sym_err, s_sym_total;
    logic [4:0]  s_bit_err;
    logic        s_err_valid, s_sat, s_lock;
    logic [1:0]  s_state;

    sym_err_cnt dut_m (
        .clk(clk), .reset(reset), .clk_en(clk_en), .hold(hold),
        .rx_data(rx_data), .ref_data(ref_data),
        .sym_err(m_sym_err), .bit_err(m_bit_err), .sym_total(m_sym_total),
        .err_valid(m_err_valid), .sat(m_sat), .lock(m_lock), .state(m_state)
    );

    sym_err_cnt #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .clk_en(clk_en), .hold(hold),
        .rx_data(rx_data), .ref_data(ref_data),
        .sym_err(s_sym_err), .bit_err(s_bit_err), .sym_total(s_sym_total),
        .err_valid(s_err_valid), .sat(s_sat), .lock(s_lock), .state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: hold count decides the phase; a queue holds the open window.
    int hc;
    int win_q[$];
    int e_se[2], e_be[2], e_tot[2], e_sat[2], e_lock[2], lc[2];
    int e_ev;
    int wid[2] = '{22, 4};

    typedef struct {
        int len, na, nb;
        int se0, be0, tot0, lk0;
        int se1, be1, tot1, sat1, lk1;
    } vec_t;
    vec_t vecs[8];

    logic       r_en, r_h;
    logic [1:0] r_rx, r_rf;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hc = 0;
        win_q.delete();
        e_ev = 0;
        for (int k = 0; k < 2; k++) begin
            e_se[k] = 0; e_be[k] = 0; e_tot[k] = 0; e_sat[k] = 0; e_lock[k] = 0; lc[k] = 0;
        end
    endtask

    task automatic model_edge();
        int n, se, be, mx, mb;
        if (reset) begin
            e_ev = 0;
            if (clk_en) begin
                win_q.push_back($countones(rx_data ^ ref_data));
                if (hold) begin
                    if (hc >= SKIP_WIN + 1) begin
                        n = win_q.size(); se = 0; be = 0;
                        foreach (win_q[i]) begin
                            se += (win_q[i] != 0) ? 1 : 0;
                            be += win_q[i];
                        end
                        for (int k = 0; k < 2; k++) begin
                            mx = (1 << wid[k]) - 1;
                            mb = (1 << (wid[k] + 1)) - 1;
                            e_tot[k] = n > mx ? mx : n;
                            e_se[k]  = se > mx ? mx : se;
                            e_be[k]  = be > mb ? mb : be;
                            e_sat[k] = (n > mx || se > mx || be > mb) ? 1 : 0;
                            if (e_se[k] <= LOCK_THR && e_sat[k] == 0)
                                lc[k] = lc[k] < LOCK_WIN ? lc[k] + 1 : lc[k];
                            else
                                lc[k] = 0;
                            e_lock[k] = lc[k] == LOCK_WIN ? 1 : 0;
                        end
                        e_ev = 1;
                    end
                    if (hc < 1000) hc++;
                    win_q.delete();
                end
            end
        end
    endtask

    task automatic compare_all();
        int es;
        es = hc == 0 ? 0 : (hc <= SKIP_WIN ? 1 : 2);
        check("m.state", m_state, es);
        check("m.err_valid", m_err_valid, e_ev);
        check("m.sym_err", m_sym_err, e_se[0]);
        check("m.bit_err", m_bit_err, e_be[0]);
        check("m.sym_total", m_sym_total, e_tot[0]);
        check("m.sat", m_sat, e_sat[0]);
        check("m.lock", m_lock, e_lock[0]);
        check("s.state", s_state, es);
        check("s.err_valid", s_err_valid, e_ev);
        check("s.sym_err", s_sym_err, e_se[1]);
        check("s.bit_err", s_bit_err, e_be[1]);
        check("s.sym_total", s_sym_total, e_tot[1]);
        check("s.sat", s_sat, e_sat[1]);
        check("s.lock", s_lock, e_lock[1]);
    endtask

    task automatic tick(input logic en, input logic h, input logic [1:0] rx, input logic [1:0] rf);
        clk_en = en; hold = h; rx_data = rx; ref_data = rf;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // na symbols with 2 bit errors, then nb with 1 bit error, rest clean; hold on the last.
    task automatic run_window(input int len, input int na, input int nb);
        logic [1:0] v;
        for (int i = 0; i < len; i++) begin
            if (i % 7 == 3) tick(1'b0, 1'b1, 2'b00, 2'b11);
            v = 2'($urandom_range(0, 3));
            if (i < na) tick(1'b1, i == len - 1, 2'b00, 2'b11);
            else if (i < na + nb) tick(1'b1, i == len - 1, 2'b01, 2'b00);
            else tick(1'b1, i == len - 1, v, v);
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        model_reset();
        #1;
        check("rst.state", m_state, 0);
        check("rst.sym_total", m_sym_total, 0);
        compare_all();
        repeat (3) tick(1'b1, 1'b1, 2'b00, 2'b11);
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{100, 3, 2,  5,  8, 100, 0,  5,  8, 15, 1, 0};
        vecs[1] = '{20, 20, 0, 20, 40,  20, 0, 15, 31, 15, 1, 0};
        vecs[2] = '{10,  0, 0,  0,  0,  10, 0,  0,  0, 10, 0, 0};
        vecs[3] = '{12,  0, 12, 12, 12, 12, 0, 12, 12, 12, 0, 0};
        vecs[4] = '{15,  0, 0,  0,  0,  15, 0,  0,  0, 15, 0, 0};
        vecs[5] = '{16,  0, 0,  0,  0,  16, 1,  0,  0, 15, 1, 0};
        vecs[6] = '{10,  0, 0,  0,  0,  10, 1,  0,  0, 10, 0, 0};
        vecs[7] = '{10,  1, 0,  1,  2,  10, 0,  1,  2, 10, 0, 0};

        reset = 1'b1; clk_en = 1'b0; hold = 1'b0; rx_data = 2'b00; ref_data = 2'b00;
        model_reset();
        #2 reset = 1'b0;
        #1 compare_all();
        repeat (2) tick(1'b1, 1'b1, 2'b00, 2'b11);
        reset = 1'b1;

        // Clean run: holds at symbols 0, 100 and 200.
        tick(1'b1, 1'b1, 2'b10, 2'b10);
        check("seq.skip_state", m_state, 1);
        run_window(100, 0, 0);
        check("seq.count_state", m_state, 2);
        check("seq.no_valid_in_skip", m_err_valid, 0);
        run_window(100, 0, 0);
        check("seq.valid", m_err_valid, 1);
        check("seq.sym_total", m_sym_total, 100);
        check("seq.sym_err", m_sym_err, 0);
        check("seq.bit_err", m_bit_err, 0);

        foreach (vecs[i]) begin
            run_window(vecs[i].len, vecs[i].na, vecs[i].nb);
            check($sformatf("vec%0d.m_valid", i), m_err_valid, 1);
            check($sformatf("vec%0d.m_sym_err", i), m_sym_err, vecs[i].se0);
            check($sformatf("vec%0d.m_bit_err", i), m_bit_err, vecs[i].be0);
            check($sformatf("vec%0d.m_sym_total", i), m_sym_total, vecs[i].tot0);
            check($sformatf("vec%0d.m_sat", i), m_sat, 0);
            check($sformatf("vec%0d.m_lock", i), m_lock, vecs[i].lk0);
            check($sformatf("vec%0d.s_sym_err", i), s_sym_err, vecs[i].se1);
            check($sformatf("vec%0d.s_bit_err", i), s_bit_err, vecs[i].be1);
            check($sformatf("vec%0d.s_sym_total", i), s_sym_total, vecs[i].tot1);
            check($sformatf("vec%0d.s_sat", i), s_sat, vecs[i].sat1);
            check($sformatf("vec%0d.s_lock", i), s_lock, vecs[i].lk1);
        end

        // hold high with clk_en low: nothing moves, and the pending err_valid still clears.
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 2'b00, 2'b11);
            check("hold_noen.state", m_state, 2);
            check("hold_noen.valid", m_err_valid, 0);
        end
        run_window(10, 0, 0);
        check("hold_noen.sym_total", m_sym_total, 10);
        check("hold_noen.sym_err", m_sym_err, 0);

        for (int c = 0; c < 3000; c++) begin
            r_en = $urandom_range(0, 3) != 0;
            r_h  = $urandom_range(0, 19) == 0;
            r_rx = 2'($urandom_range(0, 3));
            r_rf = ($urandom_range(0, c < 1500 ? 80 : 3) == 0) ? 2'($urandom_range(0, 3)) : r_rx;
            tick(r_en, r_h, r_rx, r_rf);
        end

        // Reset in the middle of a counting window.
        run_window(5, 0, 0);
        repeat (4) tick(1'b1, 1'b0, 2'b00, 2'b11);
        reset_pulse();
        check("rst.after_state", m_state, 0);
        tick(1'b1, 1'b1, 2'b11, 2'b00);
        check("rst.skip_state", m_state, 1);
        check("rst.skip_valid", m_err_valid, 0);
        run_window(5, 2, 0);
        check("rst.count_state", m_state, 2);
        check("rst.count_valid", m_err_valid, 0);
        run_window(10, 0, 1);
        check("rst.first_valid", m_err_valid, 1);
        check("rst.sym_total", m_sym_total, 10);
        check("rst.bit_err", m_bit_err, 1);
        tick(1'b1, 1'b0, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
